z80_io_ctrl: RTL and testbench
==============================

Name: z80_io_ctrl

Overview:
- Sits directly downstream of the Z80 CPU wrapper.
- Consumes the registered Z80 bus strobes (nIORQ, nMREQ, nRD, nWR) and the address/data buses.
- Generates the M1 ROM bank address, work RAM and YM2610 selects, the read-data mux and the 68k↔Z80 sound-command latches.
- Drives the Z80 nNMI input.

Parameters:
- ROM_AW, 19: width of banked sound-ROM byte address.
- BANK_RST, 32'h1E0E0602: reset values {bank2K, bank4K, bank8K, bank16K}; linear mapping.
- REPLY_RST, 8'h00: reset value of the reply latch.

Ports:
- CLK_4M  in  1  Z80 clock; same edge as the CPU wrapper.
- RESET  in  1  asynchronous, active-high reset.
- SDA  in  16  Z80 address.
- SDD_WR  in  8  Z80 write data.
- SDD_RD  out  8  read data to the Z80.
- SDD_OE  out  1  high when SDD_RD must drive the bus.
- nIORQ, nMREQ, nRD, nWR  in  1 each  Z80 strobes, active-low.
- YM_DOUT  in  8  YM2610 read data.
- nYM_CS  out  1  YM2610 select.
- YM_A  out  2  YM2610 register address = SDA[1:0].
- nROM_CS  out  1  M1 ROM select.
- ROM_ADDR  out  ROM_AW  banked ROM address.
- nRAM_CS  out  1  2 KB work RAM select.
- CODE_IN  in  8  sound code from the 68k.
- CODE_WR  in  1  one-cycle pulse; latches CODE_IN.
- REPLY_OUT  out  8  reply latch, read by the 68k.
- nNMI  out  1  to the Z80.

Behaviour:
- Reset values:
  - nYM_CS = nROM_CS = nRAM_CS = nNMI = 1; SDD_OE = 0; SDD_RD = 8'hFF.
  - Bank registers from BANK_RST; REPLY_OUT = REPLY_RST.
  - Code latch = 0; NMI enable = 0; NMI pending = 0.
- Memory decode (combinational; requires nMREQ = 0 and (nRD = 0 or nWR = 0)):
  - 0000-7FFF: nROM_CS = 0, ROM_ADDR = SDA[14:0] zero-extended.
  - 8000-BFFF: ROM_ADDR = {bank16K[4:0], SDA[13:0]}.
  - C000-DFFF: ROM_ADDR = {bank8K[5:0], SDA[12:0]}.
  - E000-EFFF: ROM_ADDR = {bank4K[6:0], SDA[11:0]}.
  - F000-F7FF: ROM_ADDR = {bank2K[7:0], SDA[10:0]}.
  - F800-FFFF: nRAM_CS = 0.
  - ROM writes are ignored; nROM_CS stays high.
- I/O decode uses port = SDA[7:0]. An I/O cycle is nIORQ = 0 with nRD = 0 or nWR = 0.
- nIORQ = 0 with both nRD and nWR high is interrupt acknowledge: no side effects, SDD_OE = 0.
- Reads:
  - 00: code latch.
  - 04-07: YM_DOUT, with nYM_CS = 0.
  - 08-0B: returns 8'hFF.
  - All other ports: 8'hFF.
- SDD_OE = ~nRD & ~nIORQ. The data mux is combinational, so data is valid in the same cycle the strobe is asserted.
- Writes: 04-07 assert nYM_CS = 0; YM data comes from SDD_WR externally.
- Side effects fire once per access, on the first CLK_4M edge where the strobe is active. Edge detect uses the registered previous (nIORQ|nRD) and (nIORQ|nWR).
  - Read 00: clear NMI pending.
  - Read 08/09/0A/0B: load bank2K / bank4K / bank8K / bank16K from SDA[15:8], truncated to register width.
  - Write 08: NMI enable = 1.
  - Write 18: NMI enable = 0.
  - Write 0C: REPLY_OUT <= SDD_WR.
- Holding a strobe for multiple cycles never re-triggers the side effect.
- NMI:
  - CODE_WR: code latch <= CODE_IN; pending <= 1.
  - nNMI is registered: nNMI <= ~(pending & enable). This gives 1 cycle latency from CODE_WR or enable.
  - Enabling while pending asserts NMI on the next edge.
  - CODE_WR in the same cycle as a port-00 read edge: pending stays 1, the latch takes the new code, and the Z80 read returns the old code.
- Asynchronous RESET during any cycle returns all state to reset values immediately.

Decomposition:
- Shared package (neo_z80_pkg): port constants (P_CODE 8'h00, P_YM 8'h04, P_NMI_EN 8'h08, P_REPLY 8'h0C, P_NMI_DIS 8'h18), region base constants, bank register widths.
- One natural sub-module, z80_bank_map: combinational SDA + bank registers → ROM_ADDR / nROM_CS / nRAM_CS.

Test Plan:
- Reset → nNMI = 1, SDD_OE = 0, REPLY_OUT = 00. Memory read at 8000 → ROM_ADDR = 0x08000; at F000 → 0x0F000.
- Z80 IN at port 0B with SDA = 0x050B → bank16K = 5. Read 9234 → ROM_ADDR = 0x15234, nROM_CS = 0.
- Write port 08, then CODE_WR with CODE_IN = 0x3C → nNMI = 0 one cycle later. Read port 00 → SDD_RD = 0x3C, nNMI = 1 the cycle after the edge.
- CODE_WR while disabled → nNMI stays 1. Write port 08 → nNMI = 0 next cycle. Write port 18 → nNMI = 1.
- Write port 0C with 0xA5 while holding nWR low for 3 cycles → REPLY_OUT = A5, single update. Int-ack cycle → SDD_OE = 0, no state change.
- CODE_WR coincident with the port-00 read edge → read returns the old code, pending stays 1, nNMI stays 0. RESET pulse mid-read → all outputs reset asynchronously.

Source files
------------

// File: rtl/neo_z80_pkg.sv
// Shared constants for the Z80 sound-side I/O controller: I/O port numbers,
// memory region bases and the layout of the ROM bank registers.
package neo_z80_pkg;

  localparam logic [7:0] P_CODE    = 8'h00;
  localparam logic [7:0] P_YM      = 8'h04;
  localparam logic [7:0] P_NMI_EN  = 8'h08;
  localparam logic [7:0] P_BANK    = 8'h08;
  localparam logic [7:0] P_REPLY   = 8'h0C;
  localparam logic [7:0] P_NMI_DIS = 8'h18;

  localparam logic [15:0] R_BANK16K = 16'h8000;
  localparam logic [15:0] R_BANK8K  = 16'hC000;
  localparam logic [15:0] R_BANK4K  = 16'hE000;
  localparam logic [15:0] R_BANK2K  = 16'hF000;
  localparam logic [15:0] R_RAM     = 16'hF800;

  localparam int B2K_W  = 8;
  localparam int B4K_W  = 7;
  localparam int B8K_W  = 6;
  localparam int B16K_W = 5;

  typedef struct packed {
    logic [B2K_W-1:0]  b2k;
    logic [B4K_W-1:0]  b4k;
    logic [B8K_W-1:0]  b8k;
    logic [B16K_W-1:0] b16k;
  } bank_regs_t;

  // Four-port group match (e.g. 04-07 or 08-0B) against a group base.
  function automatic logic in_group(input logic [7:0] port, input logic [7:0] base);
    return (port & 8'hFC) == base;
  endfunction

endpackage

// File: rtl/z80_bank_map.sv
// Combinational Z80 memory map: fixed 32 KB ROM window, four banked ROM
// windows of decreasing size, and the 2 KB work RAM at the top.
module z80_bank_map
  import neo_z80_pkg::*;
#(
  parameter int ROM_AW = 19
) (
  input  logic [15:0]       sda_i,
  input  logic              mem_rd_i,
  input  logic              mem_wr_i,
  input  bank_regs_t        banks_i,
  output logic [ROM_AW-1:0] rom_addr_o,
  output logic              nrom_cs_o,
  output logic              nram_cs_o
);

  logic [18:0] addr19;
  logic        in_ram;

  always_comb begin
    addr19 = {4'b0000, sda_i[14:0]};
    in_ram = 1'b0;
    casez (sda_i[15:11])
      5'b0????: addr19 = {4'b0000, sda_i[14:0]};
      5'b10???: addr19 = {banks_i.b16k, sda_i[13:0]};
      5'b110??: addr19 = {banks_i.b8k, sda_i[12:0]};
      5'b1110?: addr19 = {banks_i.b4k, sda_i[11:0]};
      5'b11110: addr19 = {banks_i.b2k, sda_i[10:0]};
      default:  in_ram = 1'b1;
    endcase
  end

  assign rom_addr_o = ROM_AW'(addr19);
  // ROM is read-only: a write cycle into ROM space never selects it.
  assign nrom_cs_o  = ~(mem_rd_i & ~in_ram);
  assign nram_cs_o  = ~((mem_rd_i | mem_wr_i) & in_ram);

endmodule

// File: rtl/z80_io_ctrl.sv
// Z80 sound-CPU glue: memory/ROM bank decode, YM2610 select, I/O read mux,
// 68k<->Z80 command/reply latches and the NMI used to announce new commands.
module z80_io_ctrl
  import neo_z80_pkg::*;
#(
  parameter int          ROM_AW    = 19,
  parameter logic [31:0] BANK_RST  = 32'h1E0E0602,
  parameter logic [7:0]  REPLY_RST = 8'h00
) (
  input  logic              CLK_4M,
  input  logic              RESET,
  input  logic [15:0]       SDA,
  input  logic [7:0]        SDD_WR,
  output logic [7:0]        SDD_RD,
  output logic              SDD_OE,
  input  logic              nIORQ,
  input  logic              nMREQ,
  input  logic              nRD,
  input  logic              nWR,
  input  logic [7:0]        YM_DOUT,
  output logic              nYM_CS,
  output logic [1:0]        YM_A,
  output logic              nROM_CS,
  output logic [ROM_AW-1:0] ROM_ADDR,
  output logic              nRAM_CS,
  input  logic [7:0]        CODE_IN,
  input  logic              CODE_WR,
  output logic [7:0]        REPLY_OUT,
  output logic              nNMI
);

  localparam bank_regs_t BANKS_INIT = '{
    b2k:  BANK_RST[31:24],
    b4k:  BANK_RST[22:16],
    b8k:  BANK_RST[13:8],
    b16k: BANK_RST[4:0]
  };

  logic [7:0] port;
  logic       io_rd_n, io_wr_n, io_cyc;
  logic       rd_edge, wr_edge;
  logic       mem_rd, mem_wr;

  bank_regs_t banks_q, banks_d;
  logic [7:0] code_q, code_d;
  logic [7:0] reply_q, reply_d;
  logic       pend_q, pend_d;
  logic       en_q, en_d;
  logic       nmi_n_q, nmi_n_d;
  logic       rd_prev_q, wr_prev_q;

  assign port    = SDA[7:0];
  assign io_rd_n = nIORQ | nRD;
  assign io_wr_n = nIORQ | nWR;
  assign io_cyc  = ~io_rd_n | ~io_wr_n;
  // Side effects fire only on the first active edge of a strobe.
  assign rd_edge = ~io_rd_n & rd_prev_q;
  assign wr_edge = ~io_wr_n & wr_prev_q;

  assign mem_rd  = ~nMREQ & ~nRD & ~RESET;
  assign mem_wr  = ~nMREQ & ~nWR & ~RESET;

  z80_bank_map #(
    .ROM_AW (ROM_AW)
  ) u_bank_map (
    .sda_i      (SDA),
    .mem_rd_i   (mem_rd),
    .mem_wr_i   (mem_wr),
    .banks_i    (banks_q),
    .rom_addr_o (ROM_ADDR),
    .nrom_cs_o  (nROM_CS),
    .nram_cs_o  (nRAM_CS)
  );

  assign YM_A   = SDA[1:0];
  assign nYM_CS = ~(io_cyc & in_group(port, P_YM) & ~RESET);
  assign SDD_OE = ~io_rd_n & ~RESET;

  always_comb begin
    SDD_RD = 8'hFF;
    if (SDD_OE) begin
      if (port == P_CODE)           SDD_RD = code_q;
      else if (in_group(port, P_YM)) SDD_RD = YM_DOUT;
    end
  end

  always_comb begin
    banks_d = banks_q;
    code_d  = code_q;
    reply_d = reply_q;
    pend_d  = pend_q;
    en_d    = en_q;
    nmi_n_d = ~(pend_q & en_q);

    if (rd_edge) begin
      if (port == P_CODE) pend_d = 1'b0;
      if (in_group(port, P_BANK)) begin
        case (port[1:0])
          2'd0:    banks_d.b2k  = SDA[15:8];
          2'd1:    banks_d.b4k  = SDA[14:8];
          2'd2:    banks_d.b8k  = SDA[13:8];
          default: banks_d.b16k = SDA[12:8];
        endcase
      end
    end

    if (wr_edge) begin
      if (port == P_NMI_EN)  en_d    = 1'b1;
      if (port == P_NMI_DIS) en_d    = 1'b0;
      if (port == P_REPLY)   reply_d = SDD_WR;
    end

    // A new command wins over a simultaneous acknowledge read.
    if (CODE_WR) begin
      code_d = CODE_IN;
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge CLK_4M or posedge RESET) begin
    if (RESET) begin
      banks_q   <= BANKS_INIT;
      code_q    <= 8'h00;
      reply_q   <= REPLY_RST;
      pend_q    <= 1'b0;
      en_q      <= 1'b0;
      nmi_n_q   <= 1'b1;
      rd_prev_q <= 1'b1;
      wr_prev_q <= 1'b1;
    end else begin
      banks_q   <= banks_d;
      code_q    <= code_d;
      reply_q   <= reply_d;
      pend_q    <= pend_d;
      en_q      <= en_d;
      nmi_n_q   <= nmi_n_d;
      rd_prev_q <= io_rd_n;
      wr_prev_q <= io_wr_n;
    end
  end

  assign REPLY_OUT = reply_q;
  assign nNMI      = nmi_n_q;

endmodule

// File: tb/tb_z80_io_ctrl.sv
// Bench for z80_io_ctrl: directed scenarios plus randomized bus cycles,
// checked against a behavioural model of the sound-side I/O map.
module tb_z80_io_ctrl;

  logic        clk = 1'b0;
  logic        RESET;
  logic [15:0] SDA;
  logic [7:0]  SDD_WR, SDD_RD;
  logic        SDD_OE;
  logic        nIORQ, nMREQ, nRD, nWR;
  logic [7:0]  YM_DOUT;
  logic        nYM_CS;
  logic [1:0]  YM_A;
  logic        nROM_CS;
  logic [18:0] ROM_ADDR;
  logic        nRAM_CS;
  logic [7:0]  CODE_IN;
  logic        CODE_WR;
  logic [7:0]  REPLY_OUT;
  logic        nNMI;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  z80_io_ctrl #(
    .ROM_AW    (19),
    .BANK_RST  (32'h1E0E0602),
    .REPLY_RST (8'h00)
  ) dut (
    .CLK_4M    (clk),
    .RESET     (RESET),
    .SDA       (SDA),
    .SDD_WR    (SDD_WR),
    .SDD_RD    (SDD_RD),
    .SDD_OE    (SDD_OE),
    .nIORQ     (nIORQ),
    .nMREQ     (nMREQ),
    .nRD       (nRD),
    .nWR       (nWR),
    .YM_DOUT   (YM_DOUT),
    .nYM_CS    (nYM_CS),
    .YM_A      (YM_A),
    .nROM_CS   (nROM_CS),
    .ROM_ADDR  (ROM_ADDR),
    .nRAM_CS   (nRAM_CS),
    .CODE_IN   (CODE_IN),
    .CODE_WR   (CODE_WR),
    .REPLY_OUT (REPLY_OUT),
    .nNMI      (nNMI)
  );

  // Reference model state
  int  m_code, m_reply, m_bank2, m_bank4, m_bank8, m_bank16;
  bit  m_pend, m_en, m_nmi_n, m_rd_prev, m_wr_prev;

  task automatic model_reset();
    m_code = 0; m_reply = 0; m_pend = 0; m_en = 0; m_nmi_n = 1;
    m_bank2 = 'h1E; m_bank4 = 'h0E; m_bank8 = 'h06; m_bank16 = 'h02;
    m_rd_prev = 0; m_wr_prev = 0;
  endtask

  task automatic model_edge();
    bit rd_act, wr_act, nmi_next;
    int port, hi;
    rd_act   = !nIORQ && !nRD;
    wr_act   = !nIORQ && !nWR;
    nmi_next = !(m_pend && m_en);
    port     = int'(SDA[7:0]);
    hi       = int'(SDA[15:8]);
    if (rd_act && !m_rd_prev) begin
      if (port == 0) m_pend = 0;
      if (port == 8)  m_bank2  = hi;
      if (port == 9)  m_bank4  = hi % 128;
      if (port == 10) m_bank8  = hi % 64;
      if (port == 11) m_bank16 = hi % 32;
    end
    if (wr_act && !m_wr_prev) begin
      if (port == 'h08) m_en = 1;
      if (port == 'h18) m_en = 0;
      if (port == 'h0C) m_reply = int'(SDD_WR);
    end
    if (CODE_WR) begin
      m_code = int'(CODE_IN);
      m_pend = 1;
    end
    m_nmi_n   = nmi_next;
    m_rd_prev = rd_act;
    m_wr_prev = wr_act;
  endtask

  function automatic int exp_rom_addr();
    int a, r;
    a = int'(SDA);
    if (a < 'h8000)      r = a;
    else if (a < 'hC000) r = m_bank16 * 'h4000 + (a - 'h8000);
    else if (a < 'hE000) r = m_bank8  * 'h2000 + (a - 'hC000);
    else if (a < 'hF000) r = m_bank4  * 'h1000 + (a - 'hE000);
    else                 r = m_bank2  * 'h0800 + (a - 'hF000);
    return r % (1 << 19);
  endfunction

  function automatic bit exp_oe();
    return !RESET && !nIORQ && !nRD;
  endfunction

  function automatic int exp_sdd_rd();
    int port;
    port = int'(SDA[7:0]);
    if (!exp_oe()) return 'hFF;
    if (port == 0) return m_code;
    if (port >= 4 && port <= 7) return int'(YM_DOUT);
    return 'hFF;
  endfunction

  function automatic bit exp_ym_cs_n();
    int port;
    port = int'(SDA[7:0]);
    return !(!RESET && !nIORQ && (!nRD || !nWR) && port >= 4 && port <= 7);
  endfunction

  function automatic bit exp_rom_cs_n();
    return !(!RESET && !nMREQ && !nRD && SDA < 16'hF800);
  endfunction

  function automatic bit exp_ram_cs_n();
    return !(!RESET && !nMREQ && (!nRD || !nWR) && SDA >= 16'hF800);
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // kind: 0 idle, 1 mem rd, 2 mem wr, 3 io rd, 4 io wr, 5 int-ack
  task automatic bus(input int kind, input logic [15:0] a, input logic [7:0] d);
    nMREQ = !(kind == 1 || kind == 2);
    nIORQ = !(kind == 3 || kind == 4 || kind == 5);
    nRD   = !(kind == 1 || kind == 3);
    nWR   = !(kind == 2 || kind == 4);
    SDA   = a;
    SDD_WR = d;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    CODE_WR = 1'b0; CODE_IN = 8'h00; YM_DOUT = 8'h00;
    bus(0, 16'h0000, 8'h00);
    model_reset();
    #3;
    if (nNMI !== 1'b1) begin errors++; $display("FAIL reset_nNMI: got %b want 1", nNMI); end
    checks++;
    if (SDD_OE !== 1'b0) begin errors++; $display("FAIL reset_SDD_OE: got %b want 0", SDD_OE); end
    checks++;
    if (SDD_RD !== 8'hFF) begin errors++; $display("FAIL reset_SDD_RD: got %h want ff", SDD_RD); end
    checks++;
    if (REPLY_OUT !== 8'h00) begin errors++; $display("FAIL reset_REPLY: got %h want 00", REPLY_OUT); end
    checks++;
    if ({nYM_CS, nROM_CS, nRAM_CS} !== 3'b111) begin
      errors++; $display("FAIL reset_selects: got %b want 111", {nYM_CS, nROM_CS, nRAM_CS});
    end
    checks++;
    @(negedge clk);
    RESET = 1'b0;
    tick();
    bus(1, 16'h8000, 8'h00);
    #1;
    if (ROM_ADDR !== 19'h08000 || nROM_CS !== 1'b0) begin
      errors++; $display("FAIL reset_map_8000: got %h/%b want 08000/0", ROM_ADDR, nROM_CS);
    end
    checks++;
    bus(1, 16'hF000, 8'h00);
    #1;
    if (ROM_ADDR !== 19'h0F000 || nROM_CS !== 1'b0) begin
      errors++; $display("FAIL reset_map_F000: got %h/%b want 0f000/0", ROM_ADDR, nROM_CS);
    end
    checks++;
    bus(0, 16'h0000, 8'h00);
    tick();
  endtask

  task automatic test_bank_switch();
    bus(3, 16'h050B, 8'h00);
    #1;
    if (SDD_OE !== 1'b1 || SDD_RD !== 8'hFF) begin
      errors++; $display("FAIL bank_read_data: got %b/%h want 1/ff", SDD_OE, SDD_RD);
    end
    checks++;
    tick();
    bus(0, 16'h0000, 8'h00);
    tick();
    bus(1, 16'h9234, 8'h00);
    #1;
    if (ROM_ADDR !== 19'h15234 || nROM_CS !== 1'b0) begin
      errors++; $display("FAIL bank16k_map: got %h/%b want 15234/0", ROM_ADDR, nROM_CS);
    end
    checks++;
    bus(2, 16'h9234, 8'h11);
    #1;
    if (nROM_CS !== 1'b1) begin errors++; $display("FAIL rom_write_ignored: got %b want 1", nROM_CS); end
    checks++;
    bus(0, 16'h0000, 8'h00);
    tick();
  endtask

  task automatic test_nmi();
    bus(4, 16'h0008, 8'h00);
    tick();
    bus(0, 16'h0000, 8'h00);
    tick();
    CODE_IN = 8'h3C; CODE_WR = 1'b1;
    tick();
    CODE_WR = 1'b0;
    if (nNMI !== 1'b1) begin errors++; $display("FAIL nmi_latency: got %b want 1", nNMI); end
    checks++;
    tick();
    if (nNMI !== 1'b0) begin errors++; $display("FAIL nmi_assert: got %b want 0", nNMI); end
    checks++;
    bus(3, 16'h0000, 8'h00);
    #1;
    if (SDD_RD !== 8'h3C || SDD_OE !== 1'b1) begin
      errors++; $display("FAIL nmi_code_read: got %h/%b want 3c/1", SDD_RD, SDD_OE);
    end
    checks++;
    tick();
    if (nNMI !== 1'b0) begin errors++; $display("FAIL nmi_ack_edge: got %b want 0", nNMI); end
    checks++;
    bus(0, 16'h0000, 8'h00);
    tick();
    if (nNMI !== 1'b1) begin errors++; $display("FAIL nmi_ack_release: got %b want 1", nNMI); end
    checks++;
  endtask

  task automatic test_nmi_enable();
    bus(4, 16'h0018, 8'h00);
    tick();
    bus(0, 16'h0000, 8'h00);
    tick();
    CODE_IN = 8'h55; CODE_WR = 1'b1;
    tick();
    CODE_WR = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (nNMI !== 1'b1) begin errors++; $display("FAIL nmi_disabled_%0d: got %b want 1", i, nNMI); end
      checks++;
    end
    bus(4, 16'h0008, 8'h00);
    tick();
    bus(0, 16'h0000, 8'h00);
    tick();
    if (nNMI !== 1'b0) begin errors++; $display("FAIL nmi_late_enable: got %b want 0", nNMI); end
    checks++;
    bus(4, 16'h0018, 8'h00);
    tick();
    bus(0, 16'h0000, 8'h00);
    tick();
    if (nNMI !== 1'b1) begin errors++; $display("FAIL nmi_disable: got %b want 1", nNMI); end
    checks++;
  endtask

  task automatic test_hold_and_intack();
    bus(4, 16'h000C, 8'hA5);
    tick();
    SDD_WR = 8'h5A;
    tick();
    tick();
    if (REPLY_OUT !== 8'hA5) begin errors++; $display("FAIL reply_single_update: got %h want a5", REPLY_OUT); end
    checks++;
    bus(0, 16'h0000, 8'h00);
    tick();
    bus(5, 16'h1F0B, 8'h00);
    #1;
    if (SDD_OE !== 1'b0 || SDD_RD !== 8'hFF) begin
      errors++; $display("FAIL intack_oe: got %b/%h want 0/ff", SDD_OE, SDD_RD);
    end
    checks++;
    tick();
    bus(5, 16'h0000, 8'h00);
    tick();
    bus(1, 16'h8000, 8'h00);
    #1;
    if (ROM_ADDR !== 19'h14000) begin errors++; $display("FAIL intack_no_bank: got %h want 14000", ROM_ADDR); end
    checks++;
    bus(4, 16'h0008, 8'h00);
    tick();
    bus(0, 16'h0000, 8'h00);
    tick();
    if (nNMI !== 1'b0) begin errors++; $display("FAIL intack_keeps_pending: got %b want 0", nNMI); end
    checks++;
  endtask

  task automatic test_coincident();
    bus(3, 16'h0000, 8'h00);
    CODE_IN = 8'h77; CODE_WR = 1'b1;
    #1;
    if (SDD_RD !== 8'h55) begin errors++; $display("FAIL coincident_old_code: got %h want 55", SDD_RD); end
    checks++;
    tick();
    CODE_WR = 1'b0;
    bus(0, 16'h0000, 8'h00);
    tick();
    tick();
    if (nNMI !== 1'b0) begin errors++; $display("FAIL coincident_pending: got %b want 0", nNMI); end
    checks++;
    bus(3, 16'h0000, 8'h00);
    #1;
    if (SDD_RD !== 8'h77) begin errors++; $display("FAIL coincident_new_code: got %h want 77", SDD_RD); end
    checks++;
    tick();
    bus(0, 16'h0000, 8'h00);
    tick();
  endtask

  task automatic test_async_reset();
    CODE_IN = 8'h12; CODE_WR = 1'b1;
    tick();
    CODE_WR = 1'b0;
    tick();
    YM_DOUT = 8'h9C;
    bus(3, 16'h0005, 8'h00);
    tick();
    if (nNMI !== 1'b0 || SDD_RD !== 8'h9C || nYM_CS !== 1'b0) begin
      errors++; $display("FAIL pre_reset_state: got %b/%h/%b want 0/9c/0", nNMI, SDD_RD, nYM_CS);
    end
    checks++;
    #2;
    RESET = 1'b1;
    #1;
    if (nNMI !== 1'b1 || REPLY_OUT !== 8'h00 || SDD_OE !== 1'b0 || SDD_RD !== 8'hFF || nYM_CS !== 1'b1) begin
      errors++; $display("FAIL async_reset: got nmi=%b reply=%h oe=%b rd=%h ym=%b want 1/00/0/ff/1",
                         nNMI, REPLY_OUT, SDD_OE, SDD_RD, nYM_CS);
    end
    checks++;
    model_reset();
    bus(0, 16'h0000, 8'h00);
    @(negedge clk);
    RESET = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic [7:0] ports [12];
    int kind, hold;
    logic [15:0] a;
    ports = '{8'h00, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h18, 8'h33};
    for (int n = 0; n < 400; n++) begin
      kind = $urandom_range(1, 5);
      if (kind >= 3) a = {8'($urandom), ports[$urandom_range(0, 11)]};
      else           a = 16'($urandom);
      YM_DOUT = 8'($urandom);
      bus(kind, a, 8'($urandom));
      #1;
      if (SDD_OE !== exp_oe() || SDD_RD !== 8'(exp_sdd_rd())) begin
        errors++; $display("FAIL rnd_read_mux[%0d]: got %b/%h want %b/%h", n, SDD_OE, SDD_RD, exp_oe(), 8'(exp_sdd_rd()));
      end
      checks++;
      if (nYM_CS !== exp_ym_cs_n() || nROM_CS !== exp_rom_cs_n() || nRAM_CS !== exp_ram_cs_n()) begin
        errors++; $display("FAIL rnd_selects[%0d]: got %b%b%b want %b%b%b", n, nYM_CS, nROM_CS, nRAM_CS,
                           exp_ym_cs_n(), exp_rom_cs_n(), exp_ram_cs_n());
      end
      checks++;
      if (!exp_rom_cs_n()) begin
        if (ROM_ADDR !== 19'(exp_rom_addr())) begin
          errors++; $display("FAIL rnd_rom_addr[%0d]: got %h want %h", n, ROM_ADDR, 19'(exp_rom_addr()));
        end
        checks++;
      end
      hold = $urandom_range(1, 3);
      for (int h = 0; h < hold; h++) begin
        CODE_WR = ($urandom_range(0, 5) == 0);
        CODE_IN = 8'($urandom);
        tick();
        CODE_WR = 1'b0;
        SDD_WR = 8'($urandom);
        if (nNMI !== m_nmi_n || REPLY_OUT !== 8'(m_reply)) begin
          errors++; $display("FAIL rnd_state[%0d]: got %b/%h want %b/%h", n, nNMI, REPLY_OUT, m_nmi_n, 8'(m_reply));
        end
        checks++;
      end
      bus(0, 16'h0000, 8'h00);
      tick();
      if (nNMI !== m_nmi_n) begin errors++; $display("FAIL rnd_idle_nmi[%0d]: got %b want %b", n, nNMI, m_nmi_n); end
      checks++;
    end
  endtask

  initial begin
    test_reset();
    test_bank_switch();
    test_nmi();
    test_nmi_enable();
    test_hold_and_intack();
    test_coincident();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
